// File: rtl/position_counter_pkg.sv
// Shared constants, FSM state encoding and a saturating step helper for the
// lamp position counter.
package position_counter_pkg;

  localparam int POS_W        = 5;
  localparam int DIV_W        = 8;
  localparam int DEF_MAX_POS  = 15;
  localparam int DEF_STEP_DIV = 4;
  localparam int LAMP_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    HOLD = 2'd3
  } state_t;

  // One position step in the given direction, clamped to [0, max_pos].
  function automatic logic [POS_W-1:0] sat_step(
    input logic [POS_W-1:0] pos,
    input logic             up,
    input logic [POS_W-1:0] max_pos
  );
    logic [POS_W-1:0] res;
    res = pos;
    if (up) begin
      if (pos < max_pos) res = pos + POS_W'(1);
    end else begin
      if (pos != '0) res = pos - POS_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/step_divider.sv
// Prescaler: produces a one-cycle tick every DIV qualifying cycles; any
// cycle with run low or restart high clears the count and suppresses the tick.
module step_divider
  import position_counter_pkg::*;
#(
  parameter int DIV = DEF_STEP_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick_o
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;

  always_comb begin
    tick_o       = run && !restart && (div_cnt_reg == LAST);
    div_cnt_next = div_cnt_reg + DIV_W'(1);
    if (!run || restart || tick_o) begin
      div_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
    end
  end

endmodule

// File: rtl/position_counter.sv
// Lamp position counter: prescaled up/down stepping between 0 and MAX_POS,
// with bound flags, a step pulse and a thermometer-coded lamp bar.
module position_counter
  import position_counter_pkg::*;
#(
  parameter int MAX_POS  = DEF_MAX_POS,
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              increase,
  output logic [POS_W-1:0]  position,
  output logic              at_max,
  output logic              at_min,
  output logic              step,
  output logic [LAMP_W-1:0] lamps
);

  localparam logic [POS_W-1:0] MAX_P = POS_W'(MAX_POS);

  state_t           state_reg;
  state_t           state_next;
  logic [POS_W-1:0] pos_reg;
  logic [POS_W-1:0] pos_next;
  logic             inc_reg;
  logic             step_reg;
  logic             restart;
  logic             tick;

  // A direction change restarts the prescaler so the first step in the new
  // direction comes a full period later.
  assign restart = (increase != inc_reg);

  step_divider #(
    .DIV (STEP_DIV)
  ) u_step_divider (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (enable),
    .restart (restart),
    .tick_o  (tick)
  );

  always_comb begin
    pos_next = pos_reg;
    if (tick) begin
      case (state_reg)
        UP:      pos_next = sat_step(pos_reg, 1'b1, MAX_P);
        DOWN:    pos_next = sat_step(pos_reg, 1'b0, MAX_P);
        default: pos_next = pos_reg;
      endcase
    end
  end

  // State follows the inputs and the position about to be registered, so a
  // bound reached on this edge is reported as HOLD immediately.
  always_comb begin
    state_next = IDLE;
    if (enable) begin
      if (increase) begin
        state_next = (pos_next == MAX_P) ? HOLD : UP;
      end else begin
        state_next = (pos_next == '0) ? HOLD : DOWN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pos_reg   <= '0;
      inc_reg   <= 1'b0;
      step_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      inc_reg   <= increase;
      step_reg  <= (pos_next != pos_reg);
    end
  end

  assign position = pos_reg;
  assign step     = step_reg;
  assign at_max   = (pos_reg == MAX_P);
  assign at_min   = (pos_reg == '0);

  // Lamps at or above MAX_POS can never light, so they are tied low.
  for (genvar gi = 0; gi < LAMP_W; gi++) begin : g_lamp
    if (gi < MAX_POS) begin : g_live
      assign lamps[gi] = (POS_W'(gi) < pos_reg);
    end else begin : g_dead
      assign lamps[gi] = 1'b0;
    end
  end

endmodule

// File: tb/tb_position_counter.sv
// Directed bench for position_counter: a behavioural model queues the expected
// outputs for every driven cycle; each is popped and compared after the edge.
module tb_position_counter;
  import position_counter_pkg::*;

  localparam int MAX_POS  = 15;
  localparam int STEP_DIV = 2;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              increase;
  logic [POS_W-1:0]  position;
  logic              at_max;
  logic              at_min;
  logic              step;
  logic [LAMP_W-1:0] lamps;

  typedef struct {
    int          pos;
    logic        stp;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Model state: prescaler count, position, previous direction.
  int   m_cnt  = 0;
  int   m_pos  = 0;
  logic m_prev = 1'b0;
  int   cyc    = 0;

  position_counter #(
    .MAX_POS  (MAX_POS),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .increase (increase),
    .position (position),
    .at_max   (at_max),
    .at_min   (at_min),
    .step     (step),
    .lamps    (lamps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, expv);
    end
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare.
  task automatic cycle(input logic r, input logic e, input logic i);
    exp_t x;
    exp_t got;
    logic tick;
    int   newpos;
    rst_n    = r;
    enable   = e;
    increase = i;
    if (!r) begin
      m_cnt = 0; m_pos = 0; m_prev = 1'b0;
      x.pos = 0; x.stp = 1'b0;
    end else begin
      tick   = e && (i == m_prev) && (m_cnt == STEP_DIV - 1);
      newpos = m_pos;
      if (tick) newpos = i ? ((m_pos < MAX_POS) ? m_pos + 1 : m_pos)
                           : ((m_pos > 0) ? m_pos - 1 : 0);
      m_cnt  = (!e || (i != m_prev) || tick) ? 0 : m_cnt + 1;
      x.stp  = (newpos != m_pos);
      x.pos  = newpos;
      m_pos  = newpos;
      m_prev = i;
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
    got = exp_q.pop_front();
    chk("position", 32'(position), 32'(got.pos));
    chk("step", 32'(step), 32'(got.stp));
    chk("at_max", 32'(at_max), 32'(got.pos == MAX_POS));
    chk("at_min", 32'(at_min), 32'(got.pos == 0));
    chk("lamps", lamps, (32'd1 << got.pos) - 32'd1);
    $display("cyc=%0d rst_n=%0b en=%0b inc=%0b pos=%0d step=%0b lamps=0x%08h",
             cyc, r, e, i, position, step, lamps);
  endtask

  task automatic run_until_pos(input logic e, input logic i, input int target);
    int n;
    n = 0;
    while (m_pos != target && n < 200) begin
      cycle(1'b1, e, i);
      n++;
    end
    chk("reach_target", 32'(m_pos), 32'(target));
  endtask

  initial begin
    int   step_seen;
    rst_n = 1'b0; enable = 1'b0; increase = 1'b0;

    // Reset then idle
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_at_min", 32'(at_min), 32'd1);
    chk("rst_state", 32'(dut.state_reg), 32'(IDLE));
    step_seen = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (step) step_seen = 1;
    end
    chk("idle_step_seen", 32'(step_seen), 32'd0);
    chk("idle_pos", 32'(position), 32'd0);
    chk("idle_lamps", lamps, 32'd0);

    // Count up from 0
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("up_c1_pos", 32'(position), 32'd0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("up_c2_pos", 32'(position), 32'd1);
    chk("up_c2_step", 32'(step), 32'd1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("up_c3_step", 32'(step), 32'd0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("up_c4_pos", 32'(position), 32'd2);
    chk("up_c4_lamps", lamps, 32'h3);

    // Direction change at 5
    run_until_pos(1'b1, 1'b1, 5);
    cycle(1'b1, 1'b1, 1'b0);
    chk("dir_pos", 32'(position), 32'd5);
    chk("dir_step", 32'(step), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("dir_wait_pos", 32'(position), 32'd5);
    cycle(1'b1, 1'b1, 1'b0);
    chk("dir_pos4", 32'(position), 32'd4);
    run_until_pos(1'b1, 1'b0, 0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0);
    chk("down_at_min", 32'(at_min), 32'd1);
    chk("down_hold", 32'(dut.state_reg), 32'(HOLD));

    // Enable dropped on a would-be step cycle
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    chk("gate_pos", 32'(position), 32'd0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("gate_ret1_pos", 32'(position), 32'd0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("gate_ret2_pos", 32'(position), 32'd1);

    // Saturation at MAX_POS
    step_seen = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (k >= 32 && step) step_seen = 1;
    end
    chk("sat_pos", 32'(position), 32'd15);
    chk("sat_at_max", 32'(at_max), 32'd1);
    chk("sat_state", 32'(dut.state_reg), 32'(HOLD));
    chk("sat_step_seen", 32'(step_seen), 32'd0);

    // Reset mid-count at 7 with a step pending
    run_until_pos(1'b1, 1'b0, 6);
    run_until_pos(1'b1, 1'b1, 7);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("mid_rst_pos", 32'(position), 32'd0);
    chk("mid_rst_step", 32'(step), 32'd0);
    chk("mid_rst_lamps", lamps, 32'd0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
